// File: rtl/bus_grant_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | bus_pkg: shared constants and state codes for bus_grant_arbiter.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package bus_pkg;

  localparam int NUM_SRC = 24;
  localparam int SEL_W   = 5;
  // Bit 20 is cleared: the downstream mux has no input 20.
  localparam logic [NUM_SRC-1:0] SRC_MASK = 24'hEFFFFF;

  // Source indices shared with the mux instantiation.
  localparam int SRC_FIRST = 0;
  localparam int SRC_HOLE  = 20;
  localparam int SRC_LAST  = NUM_SRC - 1;

  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] LOCK  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/bus_grant_arbiter_if.sv
// +----------------------------------------------------------------------+
// | bus_grant_arbiter_if: request/grant bundle between sources and the  |
// | arbiter. Rev 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

interface bus_grant_arbiter_if;
  logic [bus_pkg::NUM_SRC-1:0] req;
  logic                        lock;
  logic [bus_pkg::SEL_W-1:0]   sel;
  logic                        sel_valid;
  logic [bus_pkg::NUM_SRC-1:0] gnt;
  logic [15:0]                 conflict_cnt;
  logic                        bad_req;

  modport master (
    output req, lock,
    input  sel, sel_valid, gnt, conflict_cnt, bad_req
  );

  modport slave (
    input  req, lock,
    output sel, sel_valid, gnt, conflict_cnt, bad_req
  );
endinterface

`default_nettype wire

// File: rtl/bus_grant_arbiter_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick: combinational round-robin picker, first set bit from ptr.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] eff_req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  localparam logic [SEL_W:0] N_SRC = (SEL_W+1)'(NUM_SRC);

  logic [NUM_SRC-1:0] rot;
  logic [SEL_W-1:0]   pos;
  logic [SEL_W:0]     sum;

  // Rotate so ptr lands at bit 0, find the lowest set bit, then undo the rotation.
  always_comb begin
    rot = NUM_SRC'({eff_req, eff_req} >> ptr);
    pos = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) pos = SEL_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, pos};
    idx = (sum >= N_SRC) ? SEL_W'(sum - N_SRC) : sum[SEL_W-1:0];
  end

  assign any = |eff_req;

endmodule

`default_nettype wire

// File: rtl/bus_grant_arbiter.sv
// +----------------------------------------------------------------------+
// | bus_grant_arbiter: round-robin grant + registered mux select with   |
// | lock. Optional stats via macro BUS_CONFLICT_STATS_EN. Rev 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_grant_arbiter
  import bus_pkg::*;
(
  input  logic                    clk,
  input  logic                    clr_n,
  bus_grant_arbiter_if.slave      bus
);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [NUM_SRC-1:0] eff_req;
  logic [SEL_W-1:0]   ptr_after;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               hold;

  assign eff_req   = bus.req & SRC_MASK;
  assign ptr_after = (bus.sel == SEL_W'(NUM_SRC - 1)) ? '0 : bus.sel + SEL_W'(1);
  assign hold      = bus.lock & bus.req[bus.sel];
  // Leaving GRANT/LOCK re-picks from the advanced pointer in the same edge.
  assign pick_ptr  = (state == IDLE) ? ptr : ptr_after;

  rr_pick u_pick (
    .eff_req (eff_req),
    .ptr     (pick_ptr),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.sel       <= '0;
      bus.gnt       <= '0;
      bus.sel_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            bus.sel       <= pick_idx;
            bus.gnt       <= NUM_SRC'(1) << pick_idx;
            bus.sel_valid <= 1'b1;
            state         <= GRANT;
          end else begin
            bus.gnt       <= '0;
            bus.sel_valid <= 1'b0;
          end
        end
        GRANT, LOCK: begin
          if (hold) begin
            state <= LOCK;
          end else begin
            ptr <= ptr_after;
            if (pick_any) begin
              bus.sel       <= pick_idx;
              bus.gnt       <= NUM_SRC'(1) << pick_idx;
              bus.sel_valid <= 1'b1;
              state         <= GRANT;
            end else begin
              bus.gnt       <= '0;
              bus.sel_valid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: begin
          state         <= IDLE;
          bus.gnt       <= '0;
          bus.sel_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_CONFLICT_STATS_EN
  logic multi_req;
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi_req = |(eff_req & (eff_req - NUM_SRC'(1)));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus.conflict_cnt <= '0;
      bus.bad_req      <= 1'b0;
    end else begin
      if (multi_req && (bus.conflict_cnt != 16'hFFFF))
        bus.conflict_cnt <= bus.conflict_cnt + 16'd1;
      if (|(bus.req & ~SRC_MASK))
        bus.bad_req <= 1'b1;
    end
  end
`else
  assign bus.conflict_cnt = '0;
  assign bus.bad_req      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_grant_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_bus_grant_arbiter: directed + random checks against a grant model|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bus_grant_arbiter;
  import bus_pkg::*;

`ifdef BUS_CONFLICT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               clr_n = 1'b0;
  logic [NUM_SRC-1:0] req = '0;
  logic               lock = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who holds the bus, where round-robin resumes, last select.
  int         m_holder;
  int         m_ptr;
  int         m_sel;
  int         m_cnt;
  bit         m_bad;

  bus_grant_arbiter_if bif ();
  assign bif.req  = req;
  assign bif.lock = lock;

  bus_grant_arbiter u_dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [NUM_SRC-1:0] e, input int p);
    for (int k = 0; k < NUM_SRC; k++) begin
      int i;
      i = (p + k) % NUM_SRC;
      if (e[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_sel    = 0;
    m_cnt    = 0;
    m_bad    = 1'b0;
  endtask

  task automatic model_step();
    logic [NUM_SRC-1:0] eff;
    eff = req & SRC_MASK;
    if ($countones(eff) > 1 && m_cnt < 65535) m_cnt++;
    if ((req & ~SRC_MASK) != '0) m_bad = 1'b1;
    if (m_holder < 0) begin
      if (eff != '0) begin
        m_holder = pick(eff, m_ptr);
        m_sel    = m_holder;
      end
    end else if (!(lock && req[m_holder])) begin
      m_ptr = (m_holder + 1) % NUM_SRC;
      if (eff != '0) begin
        m_holder = pick(eff, m_ptr);
        m_sel    = m_holder;
      end else begin
        m_holder = -1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    req   = '0;
    lock  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic check_zero_now(input string tag);
    chk({tag, "_sel"},   32'(bif.sel), 32'd0);
    chk({tag, "_gnt"},   32'(bif.gnt), 32'd0);
    chk({tag, "_valid"}, 32'(bif.sel_valid), 32'd0);
  endtask

  initial begin
    int seq2 [4];
    int cnt [NUM_SRC];
    logic [NUM_SRC-1:0] mask_v;
    model_reset();

    fork
      forever begin
        @(posedge clk);
        if (!clr_n) model_reset();
        else        model_step();
        #1;
        chk("cmp_sel",   32'(bif.sel), 32'(m_sel));
        chk("cmp_valid", 32'(bif.sel_valid), 32'(m_holder >= 0));
        chk("cmp_gnt",   32'(bif.gnt),
            (m_holder >= 0) ? 32'(NUM_SRC'(1) << m_holder) : 32'd0);
        chk("cmp_conflict", 32'(bif.conflict_cnt), STATS ? 32'(m_cnt) : 32'd0);
        chk("cmp_bad_req",  32'(bif.bad_req), STATS ? 32'(m_bad) : 32'd0);
      end
    join_none

    // Single-cycle pulse on source 3.
    do_reset();
    check_zero_now("reset");
    req = NUM_SRC'(1) << 3;
    @(negedge clk);
    chk("t1_sel", 32'(bif.sel), 32'd3);
    chk("t1_gnt", 32'(bif.gnt), 32'h000008);
    chk("t1_valid", 32'(bif.sel_valid), 32'd1);
    req = '0;
    @(negedge clk);
    chk("t1_idle_valid", 32'(bif.sel_valid), 32'd0);
    chk("t1_idle_gnt", 32'(bif.gnt), 32'd0);
    chk("t1_idle_sel", 32'(bif.sel), 32'd3);

    // Back-to-back rotation over sources 0, 10, 11.
    do_reset();
    req = 24'h000C01;
    seq2 = '{0, 10, 11, 0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_sel", 32'(bif.sel), 32'(seq2[i]));
      chk("t2_valid", 32'(bif.sel_valid), 32'd1);
    end
    chk("t2_conflict", 32'(bif.conflict_cnt), STATS ? 32'd4 : 32'd0);
    req = '0;
    @(negedge clk);

    // Park ptr at 23 via a grant to 22, then check the wrap 23 -> 0.
    req = NUM_SRC'(1) << 22;
    @(negedge clk);
    chk("t3_sel22", 32'(bif.sel), 32'd22);
    req = '0;
    @(negedge clk);
    req = (NUM_SRC'(1) << 23) | NUM_SRC'(1);
    @(negedge clk);
    chk("t3_sel23", 32'(bif.sel), 32'd23);
    @(negedge clk);
    chk("t3_sel0", 32'(bif.sel), 32'd0);
    req = '0;
    @(negedge clk);

    // Masked source 20 is never granted.
    req = NUM_SRC'(1) << SRC_HOLE;
    repeat (3) begin
      @(negedge clk);
      chk("t4_valid", 32'(bif.sel_valid), 32'd0);
      chk("t4_gnt", 32'(bif.gnt), 32'd0);
      chk("t4_bad_req", 32'(bif.bad_req), STATS ? 32'd1 : 32'd0);
    end
    req = '0;

    // Lock on source 5 for four cycles, then 6 takes over.
    do_reset();
    req  = (NUM_SRC'(1) << 5) | (NUM_SRC'(1) << 6);
    lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_sel5", 32'(bif.sel), 32'd5);
      chk("t5_gnt5", 32'(bif.gnt), 32'h000020);
    end
    lock = 1'b0;
    @(negedge clk);
    chk("t5_sel6", 32'(bif.sel), 32'd6);
    req = '0;
    @(negedge clk);

    // Async reset mid-LOCK; the next grant must start from ptr 0.
    req = NUM_SRC'(1) << 2;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    req  = (NUM_SRC'(1) << 5) | (NUM_SRC'(1) << 1);
    lock = 1'b1;
    @(negedge clk);
    chk("t6_pre_sel", 32'(bif.sel), 32'd5);
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1 check_zero_now("t6_async");
    @(negedge clk);
    lock  = 1'b0;
    clr_n = 1'b1;
    @(negedge clk);
    chk("t6_first_sel", 32'(bif.sel), 32'd1);
    req = '0;

    // Fairness: all requesting, 46 grants -> twice each for live sources.
    do_reset();
    req    = '1;
    mask_v = SRC_MASK;
    for (int i = 0; i < NUM_SRC; i++) cnt[i] = 0;
    repeat (46) begin
      @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++) if (bif.gnt[i]) cnt[i]++;
    end
    for (int i = 0; i < NUM_SRC; i++)
      chk("fair_cnt", 32'(cnt[i]), mask_v[i] ? 32'd2 : 32'd0);

    // Randomized traffic with occasional async resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 40) begin
        case ($urandom_range(0, 3))
          0: req = '0;
          1: req = NUM_SRC'(1) << $urandom_range(0, NUM_SRC - 1);
          2: req = NUM_SRC'($urandom & $urandom);
          default: req = NUM_SRC'($urandom);
        endcase
      end
      lock = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 99) < 2) begin
        #2 clr_n = 1'b0;
        #1 check_zero_now("rnd_async");
        @(negedge clk);
        clr_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
